// File: rtl/rename_unit.sv
// Register rename stage: maps architectural sources/destination to physical tags,
// tracks a retirement map from ROB commits and restores the speculative map on flush.
module rename_unit #(
    parameter int NPHYS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        in_reg_write,
    input  logic [31:0] in_PC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_PC,
    output logic        out_reg_write,
    output logic [6:0]  out_phys_addr,
    output logic [6:0]  out_src1_phys,
    output logic [6:0]  out_src2_phys,
    input  logic        commit_reg_write,
    input  logic [4:0]  commit_dest,
    input  logic [6:0]  commit_phys_addr,
    input  logic        commit_valid,
    input  logic        flush,
    output logic [7:0]  free_count
);

    logic [6:0]       spec_rat_reg [32];
    logic [6:0]       ret_rat_reg  [32];
    logic [6:0]       ret_rat_next [32];
    logic [NPHYS-1:0] free_mask_reg;
    logic [NPHYS-1:0] free_mask_next;
    logic [NPHYS-1:0] used_next;
    logic [7:0]       free_count_reg;
    logic [7:0]       free_count_next;

    logic             out_valid_reg;
    logic [31:0]      out_instr_reg;
    logic [31:0]      out_pc_reg;
    logic             out_reg_write_reg;
    logic [6:0]       out_phys_addr_reg;
    logic [6:0]       out_src1_reg;
    logic [6:0]       out_src2_reg;

    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             accept;
    logic             do_alloc;
    logic             commit_fire;
    logic [6:0]       commit_old;
    logic [6:0]       alloc_tag;
    logic [31:0]      commit_hit;
    logic [31:0]      alloc_hit;

    assign rd  = in_instr[11:7];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];

    // A free register is demanded even for non-writers so ready never depends on the instruction.
    assign in_ready    = (!out_valid_reg || out_ready) && (free_count_reg != 8'd0) && !flush;
    assign accept      = in_valid && in_ready && (in_instr != 32'd0);
    assign do_alloc    = accept && in_reg_write && (rd != 5'd0);
    assign commit_fire = commit_valid && commit_reg_write && (commit_dest != 5'd0);
    assign commit_old  = ret_rat_reg[commit_dest];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_hit
            assign commit_hit[gi] = commit_fire && (commit_dest == 5'(gi));
            assign alloc_hit[gi]  = do_alloc && (rd == 5'(gi));
        end
    endgenerate

    // Lowest-index free register; p0 is never a candidate.
    always_comb begin
        alloc_tag = 7'd0;
        for (int i = NPHYS - 1; i >= 1; i--) begin
            if (free_mask_reg[i]) begin
                alloc_tag = 7'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            ret_rat_next[i] = commit_hit[i] ? commit_phys_addr : ret_rat_reg[i];
        end
    end

    always_comb begin
        used_next = '0;
        for (int i = 0; i < 32; i++) begin
            used_next[ret_rat_next[i]] = 1'b1;
        end
    end

    // The allocated tag comes from the old free set and the freed tag was in use, so they never collide.
    always_comb begin
        free_mask_next = free_mask_reg;
        if (flush) begin
            free_mask_next    = ~used_next;
            free_mask_next[0] = 1'b0;
        end else begin
            if (do_alloc) begin
                free_mask_next[alloc_tag] = 1'b0;
            end
            if (commit_fire) begin
                free_mask_next[commit_old] = 1'b1;
            end
        end
    end

    assign free_count_next = 8'($countones(free_mask_next));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                spec_rat_reg[i] <= 7'(i);
                ret_rat_reg[i]  <= 7'(i);
            end
            free_mask_reg  <= {{(NPHYS-32){1'b1}}, 32'd0};
            free_count_reg <= 8'(NPHYS - 32);
        end else begin
            for (int i = 0; i < 32; i++) begin
                ret_rat_reg[i] <= ret_rat_next[i];
                if (flush) begin
                    spec_rat_reg[i] <= ret_rat_next[i];
                end else if (alloc_hit[i]) begin
                    spec_rat_reg[i] <= alloc_tag;
                end
            end
            free_mask_reg  <= free_mask_next;
            free_count_reg <= free_count_next;
        end
    end

    // Output register: loads on accept, holds under backpressure, drops on flush or drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg     <= 1'b0;
            out_instr_reg     <= 32'd0;
            out_pc_reg        <= 32'd0;
            out_reg_write_reg <= 1'b0;
            out_phys_addr_reg <= 7'd0;
            out_src1_reg      <= 7'd0;
            out_src2_reg      <= 7'd0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg     <= 1'b1;
            out_instr_reg     <= in_instr;
            out_pc_reg        <= in_PC;
            out_reg_write_reg <= in_reg_write;
            out_phys_addr_reg <= do_alloc ? alloc_tag : 7'd0;
            out_src1_reg      <= spec_rat_reg[rs1];
            out_src2_reg      <= spec_rat_reg[rs2];
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_instr     = out_instr_reg;
    assign out_PC        = out_pc_reg;
    assign out_reg_write = out_reg_write_reg;
    assign out_phys_addr = out_phys_addr_reg;
    assign out_src1_phys = out_src1_reg;
    assign out_src2_phys = out_src2_reg;
    assign free_count    = free_count_reg;

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed table, corner sequences and
// randomized traffic against an array-level rename model.
module tb_rename_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_reg_write;
    logic [31:0] in_PC;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_PC;
    logic        out_reg_write;
    logic [6:0]  out_phys_addr;
    logic [6:0]  out_src1_phys;
    logic [6:0]  out_src2_phys;
    logic        commit_reg_write;
    logic [4:0]  commit_dest;
    logic [6:0]  commit_phys_addr;
    logic        commit_valid;
    logic        flush;
    logic [7:0]  free_count;

    always #5 clk = ~clk;

    rename_unit #(.NPHYS(128)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_reg_write(in_reg_write), .in_PC(in_PC),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_PC(out_PC), .out_reg_write(out_reg_write), .out_phys_addr(out_phys_addr),
        .out_src1_phys(out_src1_phys), .out_src2_phys(out_src2_phys),
        .commit_reg_write(commit_reg_write), .commit_dest(commit_dest),
        .commit_phys_addr(commit_phys_addr), .commit_valid(commit_valid),
        .flush(flush), .free_count(free_count)
    );

    // Reference model state.
    int          m_spec [32];
    int          m_ret  [32];
    bit          m_free [128];
    bit          m_ov;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_rw;
    int          m_dest, m_s1, m_s2;

    typedef struct { int rd; int tag; } pend_t;
    pend_t pq[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic        rw;
        int          e_s1;
        int          e_s2;
        int          e_dest;
        int          e_fc;
    } vec_t;
    vec_t tv [5];

    function automatic logic [31:0] mk(input int rd, input int r1, input int r2);
        return {7'd0, 5'(r2), 5'(r1), 3'd0, 5'(rd), 7'h33};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 128; i++) c += int'(m_free[i]);
        return c;
    endfunction

    function automatic bit m_ready();
        return (!m_ov || out_ready) && (m_count() != 0) && !flush;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = i;
            m_ret[i]  = i;
        end
        for (int i = 0; i < 128; i++) m_free[i] = (i >= 32);
        m_ov = 0; m_instr = 0; m_pc = 0; m_rw = 0;
        m_dest = 0; m_s1 = 0; m_s2 = 0;
        pq.delete();
    endtask

    // One clock edge of the rename rules, evaluated on the inputs present at the edge.
    task automatic model_edge();
        bit acc;
        int alloc, rd, old;
        acc   = in_valid && m_ready() && (in_instr != 0);
        rd    = int'(in_instr[11:7]);
        alloc = 0;
        if (acc && in_reg_write && rd != 0) begin
            for (int i = 127; i >= 1; i--) if (m_free[i]) alloc = i;
        end
        if (commit_valid && commit_reg_write && commit_dest != 0) begin
            old = m_ret[commit_dest];
            m_ret[commit_dest] = int'(commit_phys_addr);
            m_free[old] = 1;
        end
        if (flush) begin
            for (int i = 0; i < 128; i++) m_free[i] = 1;
            for (int i = 0; i < 32; i++) begin
                m_spec[i] = m_ret[i];
                m_free[m_ret[i]] = 0;
            end
            m_free[0] = 0;
            m_ov = 0;
            pq.delete();
        end else if (acc) begin
            m_s1    = m_spec[in_instr[19:15]];
            m_s2    = m_spec[in_instr[24:20]];
            m_ov    = 1;
            m_instr = in_instr;
            m_pc    = in_PC;
            m_rw    = in_reg_write;
            m_dest  = alloc;
            if (alloc != 0) begin
                m_free[alloc] = 0;
                m_spec[rd] = alloc;
                pq.push_back('{rd, alloc});
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_instr", out_instr, m_instr);
        chk("out_PC", out_PC, m_pc);
        chk("out_reg_write", 32'(out_reg_write), 32'(m_rw));
        chk("out_phys_addr", 32'(out_phys_addr), 32'(m_dest));
        chk("out_src1_phys", 32'(out_src1_phys), 32'(m_s1));
        chk("out_src2_phys", 32'(out_src2_phys), 32'(m_s2));
        chk("free_count", 32'(free_count), 32'(m_count()));
    endtask

    // Inputs must already be driven; checks ready before the edge and outputs after it.
    task automatic cycle();
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_instr = 0; in_reg_write = 0; in_PC = 0; out_ready = 1;
        commit_valid = 0; commit_reg_write = 0; commit_dest = 0; commit_phys_addr = 0;
        flush = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic send(input int rd, input int r1, input int r2, input bit rw);
        in_valid = 1; in_instr = mk(rd, r1, r2); in_reg_write = rw;
        in_PC = $urandom;
        cycle();
    endtask

    logic [31:0] held_instr;
    logic [6:0]  held_dest, held_s1;

    initial begin
        tv[0] = '{mk(5, 1, 2), 1'b1, 1, 2, 32, 95};
        tv[1] = '{mk(6, 5, 5), 1'b1, 32, 32, 33, 94};
        tv[2] = '{mk(0, 6, 3), 1'b1, 33, 3, 0, 94};
        tv[3] = '{mk(7, 6, 5), 1'b0, 33, 32, 0, 94};
        tv[4] = '{mk(5, 5, 6), 1'b1, 32, 33, 34, 93};

        // Reset state.
        do_reset();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_free_count", 32'(free_count), 32'd96);
        chk("reset_phys_addr", 32'(out_phys_addr), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed table: back-to-back renames.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; in_instr = tv[k].instr; in_reg_write = tv[k].rw;
            in_PC = 32'h1000 + 32'(4 * k);
            cycle();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_src1", 32'(out_src1_phys), 32'(tv[k].e_s1));
            chk("tbl_src2", 32'(out_src2_phys), 32'(tv[k].e_s2));
            chk("tbl_dest", 32'(out_phys_addr), 32'(tv[k].e_dest));
            chk("tbl_fc", 32'(free_count), 32'(tv[k].e_fc));
            chk("tbl_pc", out_PC, 32'h1000 + 32'(4 * k));
        end
        // Bubble: consumed, no output.
        in_instr = 0; in_reg_write = 1;
        cycle();
        chk("bubble_valid", 32'(out_valid), 32'd0);
        chk("bubble_fc", 32'(free_count), 32'd93);

        // Exhaustion and commit-driven recovery.
        do_reset();
        for (int k = 0; k < 96; k++) send(((k + 4) % 31) + 1, 1, 2, 1);
        chk("exhaust_fc", 32'(free_count), 32'd0);
        in_instr = mk(9, 1, 2);
        #1;
        chk("exhaust_ready", 32'(in_ready), 32'd0);
        in_valid = 0;
        commit_valid = 1; commit_reg_write = 1; commit_dest = 5; commit_phys_addr = 32;
        cycle();
        commit_valid = 0;
        chk("commit_fc", 32'(free_count), 32'd1);
        in_valid = 1; in_instr = mk(9, 5, 1); in_reg_write = 1;
        #1;
        chk("recover_ready", 32'(in_ready), 32'd1);
        cycle();
        chk("recover_dest", 32'(out_phys_addr), 32'd5);

        // Backpressure hold.
        do_reset();
        send(5, 1, 2, 1);
        held_instr = out_instr; held_dest = out_phys_addr; held_s1 = out_src1_phys;
        out_ready = 0; in_instr = mk(6, 5, 3);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_instr", out_instr, held_instr);
            chk("hold_dest", 32'(out_phys_addr), 32'(held_dest));
            chk("hold_src1", 32'(out_src1_phys), 32'(held_s1));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        cycle();
        chk("release_dest", 32'(out_phys_addr), 32'd33);
        chk("release_src1", 32'(out_src1_phys), 32'd32);
        send(7, 6, 6, 1);
        chk("resume_dest", 32'(out_phys_addr), 32'd34);

        // Flush restores the retirement map.
        do_reset();
        send(5, 1, 2, 1);
        send(5, 5, 2, 1);
        in_valid = 0;
        commit_valid = 1; commit_reg_write = 1; commit_dest = 5; commit_phys_addr = 32;
        cycle();
        commit_valid = 0;
        flush = 1;
        cycle();
        flush = 0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_fc", 32'(free_count), 32'd96);
        send(7, 5, 0, 1);
        chk("flush_src1", 32'(out_src1_phys), 32'd32);
        chk("flush_alloc_p5", 32'(out_phys_addr), 32'd5);
        send(8, 7, 0, 1);
        chk("flush_alloc_p33", 32'(out_phys_addr), 32'd33);

        // Asynchronous reset mid-operation.
        do_reset();
        for (int k = 0; k < 86; k++) send((k % 31) + 1, 2, 3, 1);
        chk("pre_rst_fc", 32'(free_count), 32'd10);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_fc", 32'(free_count), 32'd96);
        chk("async_rst_dest", 32'(out_phys_addr), 32'd0);
        chk("async_rst_instr", out_instr, 32'd0);
        do_reset();

        // Randomized traffic with in-order commits of previously renamed writers.
        for (int k = 0; k < 3000; k++) begin
            in_valid     = ($urandom_range(0, 99) < 80);
            in_instr     = ($urandom_range(0, 19) == 0) ? 32'd0 : 32'($urandom);
            in_reg_write = ($urandom_range(0, 9) < 7);
            in_PC        = $urandom;
            out_ready    = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 99) < 2);
            commit_valid = 0; commit_reg_write = 0;
            commit_dest  = 5'($urandom); commit_phys_addr = 7'($urandom);
            if (pq.size() != 0 && $urandom_range(0, 9) < 4) begin
                pend_t p;
                p = pq.pop_front();
                commit_valid = 1; commit_reg_write = 1;
                commit_dest = 5'(p.rd); commit_phys_addr = 7'(p.tag);
            end else if ($urandom_range(0, 9) == 0) begin
                commit_valid = 1;
            end
            cycle();
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
